// File: rtl/keccak_padder.sv
// SHA-3 padder: turns a stream of 64-bit message lanes into padded RATE-bit blocks
// and feeds them one word per cycle to the Keccak rate buffer.
module keccak_padder #(
    parameter int RATE = 1088
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [63:0] Din,
    input  logic        Din_valid,
    input  logic        Din_last,
    input  logic [3:0]  Din_bytes,
    output logic        Din_ready,
    input  logic        Buffer_full,
    output logic [63:0] Dout,
    output logic        Dout_valid,
    output logic        Last_block,
    output logic        Busy
);

    localparam int N  = 64;
    localparam int NW = RATE / N;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [WW-1:0] LAST_IDX = WW'(NW - 1);

    typedef enum logic [1:0] {ABSORB, PAD, FILL, FLUSH} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] widx;
    logic          gap;
    logic          full_seen;
    logic          emit;
    logic          set_last;
    logic          clr_last;
    logic [N-1:0]  word;
    logic          last_pos;
    logic          go;
    logic [3:0]    nbytes;

    // Keep bytes below b, drop the rest, put the domain byte at b and the final bit if needed.
    function automatic logic [N-1:0] pad_word(input logic [N-1:0] d, input logic [3:0] b,
                                              input logic fin);
        logic [N-1:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(b))
                w[8*k +: 8] = d[8*k +: 8];
            else if (k == int'(b))
                w[8*k +: 8] = 8'h06;
        end
        if (fin)
            w[N-1 -: 8] = w[N-1 -: 8] | 8'h80;
        return w;
    endfunction

    assign last_pos = (widx == LAST_IDX);
    // The cycle after word NW-1 is held idle so the buffer has time to raise Buffer_full.
    assign go       = ~Buffer_full & ~gap;
    assign nbytes   = (Din_bytes > 4'd8) ? 4'd8 : Din_bytes;
    assign Busy     = (state != ABSORB) || (widx != '0);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        state_nxt = state;
        emit      = 1'b0;
        word      = '0;
        set_last  = 1'b0;
        clr_last  = 1'b0;
        Din_ready = (state == ABSORB) & go;
        case (state)
            ABSORB: begin
                if (Din_valid && Din_ready) begin
                    emit = 1'b1;
                    if (!Din_last) begin
                        word = Din;
                    end else if (nbytes == 4'd8) begin
                        word      = Din;
                        state_nxt = PAD;
                    end else begin
                        word = pad_word(Din, nbytes, last_pos);
                        if (last_pos) begin
                            set_last  = 1'b1;
                            state_nxt = FLUSH;
                        end else begin
                            state_nxt = FILL;
                        end
                    end
                end
            end
            PAD: begin
                if (go) begin
                    emit = 1'b1;
                    word = pad_word('0, 4'd0, last_pos);
                    if (last_pos) begin
                        set_last  = 1'b1;
                        state_nxt = FLUSH;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                if (go) begin
                    emit = 1'b1;
                    if (last_pos) begin
                        word      = {8'h80, 56'h0};
                        set_last  = 1'b1;
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (full_seen && !Buffer_full) begin
                    clr_last  = 1'b1;
                    state_nxt = ABSORB;
                end
            end
            default: state_nxt = ABSORB;
        endcase
    end

    // NOTE: all state below is updated with non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= ABSORB;
            widx       <= '0;
            gap        <= 1'b0;
            full_seen  <= 1'b0;
            Dout       <= '0;
            Dout_valid <= 1'b0;
            Last_block <= 1'b0;
        end else begin
            state      <= state_nxt;
            Dout_valid <= emit;
            gap        <= emit & last_pos;
            if (emit) begin
                Dout <= word;
                widx <= last_pos ? '0 : widx + WW'(1);
            end
            if (set_last)
                Last_block <= 1'b1;
            else if (clr_last)
                Last_block <= 1'b0;
            if (state == FLUSH && Buffer_full)
                full_seen <= 1'b1;
            else if (clr_last)
                full_seen <= 1'b0;
        end
    end

endmodule
